switch_key_port: RTL and testbench

//  Memory-mapped input peripheral through which the processor reads the board inputs (SW, push-buttons).
//  The board model drives SW/KEY into setup; this block is the processor-side reader of those signals.
//  - Synchronises switches; synchronises and debounces keys.
//  - Captures key-press edges; exposes level and edge registers on the processor read bus.
//  - Sits beside the LED/HEX output ports in setup, on the same ADDR/DOUT/W bus.

---
 rtl/io_map_pkg.sv | 23 ++
 rtl/key_debouncer.sv | 54 +++++
 rtl/switch_key_port.sv | 104 ++++++++++
 tb/tb_switch_key_port.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// I/O map shared by the memory-mapped board ports: base decodes, register
// offsets and the processor data width.
package io_map_pkg;

  localparam int DATA_W = 16;

  // ADDR[15:12] decode values for each I/O port
  localparam logic [3:0] BASE_LED   = 4'h1;
  localparam logic [3:0] BASE_HEX   = 4'h2;
  localparam logic [3:0] BASE_SWKEY = 4'h3;

  // Register offsets (ADDR[1:0]) inside the switch/key port
  localparam logic [1:0] OFF_SW   = 2'd0;
  localparam logic [1:0] OFF_KEY  = 2'd1;
  localparam logic [1:0] OFF_EDGE = 2'd2;
  localparam logic [1:0] OFF_RSVD = 2'd3;

  // True when the address falls inside the 4 KiB window of the given port
  function automatic logic port_hit(input logic [15:0] addr, input logic [3:0] base);
    return addr[15:12] == base;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: two-flop synchroniser, stability counter, accepted level
// and a single-cycle pulse on an accepted press.
module key_debouncer #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic rise
);

  localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             press_p0;
  logic             press_p1;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  // Synchroniser; the key is inverted on entry so a cleared chain reads as released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_p0 <= 1'b0;
      press_p1 <= 1'b0;
    end else begin
      press_p0 <= ~key_n;
      press_p1 <= press_p0;
    end
  end

  assign differ = press_p1 ^ level;
  assign accept = differ && (cnt == CNT_LAST);

  // Count consecutive differing cycles; flip the accepted level once the count is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (!differ) begin
      cnt   <= '0;
    end else if (accept) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Press edge coincides with the accepted level flipping from released to pressed
  assign rise = accept & ~level;

endmodule

// File: rtl/switch_key_port.sv
// Processor-side reader for the board slide switches and push-buttons.
// Switches are synchronised, keys synchronised and debounced; accepted key
// presses are latched in a sticky write-1-to-clear edge register. Reads are
// registered with one cycle of latency and return zero when not selected so
// the port can be OR'ed onto the shared read-data bus.
module switch_key_port
  import io_map_pkg::*;
#(
  parameter int         SW_WIDTH  = 10,
  parameter int         KEY_WIDTH = 3,
  parameter int         DB_CYCLES = 500000,
  parameter logic [3:0] BASE      = BASE_SWKEY
) (
  input  logic                 CLOCK_50,
  input  logic                 Resetn,
  input  logic [15:0]          ADDR,
  input  logic                 W,
  input  logic [DATA_W-1:0]    DOUT,
  input  logic [SW_WIDTH-1:0]  SW,
  input  logic [KEY_WIDTH-1:0] KEY,
  output logic [DATA_W-1:0]    port_data,
  output logic                 key_pending
);

  logic [SW_WIDTH-1:0]  sw_p0;
  logic [SW_WIDTH-1:0]  sw_p1;
  logic [KEY_WIDTH-1:0] key_level;
  logic [KEY_WIDTH-1:0] key_rise;
  logic [KEY_WIDTH-1:0] key_edge;
  logic [KEY_WIDTH-1:0] key_edge_nxt;
  logic [KEY_WIDTH-1:0] clr_mask;
  logic [DATA_W-1:0]    rd_mux;
  logic                 sel;
  logic [1:0]           off;
  logic                 unused_bits;

  // Only the window decode and the offset bits of ADDR matter here
  assign unused_bits = ^{ADDR[11:2], DOUT[DATA_W-1:KEY_WIDTH]};

  // Two-flop synchroniser for the slide switches
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= SW;
      sw_p1 <= sw_p0;
    end
  end

  genvar gi;
  for (gi = 0; gi < KEY_WIDTH; gi++) begin : g_key
    key_debouncer #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk   (CLOCK_50),
      .rst_n (Resetn),
      .key_n (KEY[gi]),
      .level (key_level[gi]),
      .rise  (key_rise[gi])
    );
  end

  // Address decode, W1C mask (a same-cycle press overrides the clear) and read mux
  always_comb begin
    sel          = port_hit(ADDR, BASE);
    off          = ADDR[1:0];
    clr_mask     = '0;
    rd_mux       = '0;
    if (sel && W && (off == OFF_EDGE)) begin
      clr_mask = DOUT[KEY_WIDTH-1:0];
    end
    key_edge_nxt = (key_edge & ~clr_mask) | key_rise;
    if (sel) begin
      case (off)
        OFF_SW:   rd_mux[SW_WIDTH-1:0]  = sw_p1;
        OFF_KEY:  rd_mux[KEY_WIDTH-1:0] = key_level;
        OFF_EDGE: rd_mux[KEY_WIDTH-1:0] = key_edge;
        default:  rd_mux                = '0;
      endcase
    end
  end

  // Sticky edge register with its summary flag kept in the same cycle
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      key_edge    <= '0;
      key_pending <= 1'b0;
    end else begin
      key_edge    <= key_edge_nxt;
      key_pending <= |key_edge_nxt;
    end
  end

  // Registered read data; the edge register is read before any clear lands
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      port_data <= '0;
    end else begin
      port_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_switch_key_port.sv
// Bench for switch_key_port with DB_CYCLES=4: directed scenarios plus a
// randomized run, all checked against a behavioural reference model through
// a scoreboard queue that a negedge monitor drains.
module tb_switch_key_port;

  localparam int DB = 4;

  logic        CLOCK_50;
  logic        Resetn;
  logic [15:0] ADDR;
  logic        W;
  logic [15:0] DOUT;
  logic [9:0]  SW;
  logic [2:0]  KEY;
  logic [15:0] port_data;
  logic        key_pending;

  switch_key_port #(
    .SW_WIDTH  (10),
    .KEY_WIDTH (3),
    .DB_CYCLES (DB),
    .BASE      (4'h3)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .Resetn      (Resetn),
    .ADDR        (ADDR),
    .W           (W),
    .DOUT        (DOUT),
    .SW          (SW),
    .KEY         (KEY),
    .port_data   (port_data),
    .key_pending (key_pending)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          tgt;
    logic [15:0] pd;
    logic        pend;
  } exp_t;
  exp_t q[$];

  // Reference model state: raw inputs seen one and two edges ago, accepted
  // key levels, how long each synced key has disagreed, and sticky presses.
  logic [9:0] m_sw1, m_sw2;
  logic [2:0] m_k1, m_k2, m_lvl, m_edge;
  int         m_run[3];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_sw1 = '0; m_sw2 = '0; m_k1 = '0; m_k2 = '0; m_lvl = '0; m_edge = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endtask

  // Drive one cycle of inputs, predict what the DUT shows after the next edge, advance
  task automatic cycle_in(input logic [15:0] a, input logic w_i, input logic [15:0] d,
                          input logic [9:0] sw_i, input logic [2:0] key_i);
    exp_t        e;
    logic        hit;
    logic [15:0] pd;
    logic [2:0]  rise, clr;
    ADDR = a; W = w_i; DOUT = d; SW = sw_i; KEY = key_i;
    hit  = (a[15:12] == 4'h3);
    pd   = '0;
    if (hit) begin
      if (a[1:0] == 2'd0)      pd = {6'b0, m_sw2};
      else if (a[1:0] == 2'd1) pd = {13'b0, m_lvl};
      else if (a[1:0] == 2'd2) pd = {13'b0, m_edge};
    end
    rise = '0;
    for (int i = 0; i < 3; i++) begin
      if (m_k2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          rise[i]  = m_lvl[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    clr    = (hit && w_i && a[1:0] == 2'd2) ? d[2:0] : 3'b000;
    m_edge = (m_edge & ~clr) | rise;
    e.tgt  = cyc + 1;
    e.pd   = pd;
    e.pend = |m_edge;
    q.push_back(e);
    m_sw2 = m_sw1; m_sw1 = sw_i;
    m_k2  = m_k1;  m_k1  = ~key_i;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset(input int n);
    Resetn = 1'b0;
    q.delete();
    m_reset();
    #1;
    chk("reset_port_data", port_data, 16'h0000);
    chk("reset_key_pending", {15'b0, key_pending}, 16'h0000);
    repeat (n) @(posedge CLOCK_50);
    #1;
    Resetn = 1'b1;
  endtask

  // Scoreboard monitor: compare whenever an expectation falls due
  always @(negedge CLOCK_50) begin
    if (q.size() > 0 && q[0].tgt == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_port_data", port_data, e.pd);
      chk("sb_key_pending", {15'b0, key_pending}, {15'b0, e.pend});
    end
  end

  initial begin
    logic [9:0]  sw_r;
    logic [2:0]  key_r;
    logic [15:0] a;
    Resetn = 1'b0; ADDR = 16'h1000; W = 1'b0; DOUT = '0; SW = 10'h3FF; KEY = 3'b111;
    m_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;

    // Reset with all switches on, then read them through the synchroniser
    do_reset(2);
    repeat (3) cycle_in(16'h3000, 1'b0, 16'h0, 10'h3FF, 3'b111);
    chk("sw_after_reset", port_data, 16'h03FF);

    // One-cycle read latency; other port's window reads zero
    repeat (3) cycle_in(16'h1000, 1'b0, 16'h0, 10'h203, 3'b111);
    chk("unselected_zero", port_data, 16'h0000);
    cycle_in(16'h3000, 1'b0, 16'h0, 10'h203, 3'b111);
    chk("sw_read", port_data, 16'h0203);

    // Short bounce is rejected
    repeat (2) cycle_in(16'h3001, 1'b0, 16'h0, 10'h203, 3'b110);
    repeat (8) cycle_in(16'h3001, 1'b0, 16'h0, 10'h203, 3'b111);
    chk("bounce_level", port_data, 16'h0000);
    cycle_in(16'h3002, 1'b0, 16'h0, 10'h203, 3'b111);
    chk("bounce_edge", port_data, 16'h0000);

    // Held press accepted after 2 + DB cycles
    for (int i = 1; i <= 10; i++) begin
      cycle_in(16'h3001, 1'b0, 16'h0, 10'h203, 3'b110);
      if (i == 5) chk("press_pending_early", {15'b0, key_pending}, 16'h0000);
      if (i == 6) chk("press_pending", {15'b0, key_pending}, 16'h0001);
      if (i == 7) chk("press_level", port_data, 16'h0001);
    end
    cycle_in(16'h3002, 1'b0, 16'h0, 10'h203, 3'b110);
    chk("press_edge", port_data, 16'h0001);

    // W1C returns the pre-clear value and clears
    cycle_in(16'h3002, 1'b1, 16'h0001, 10'h203, 3'b110);
    chk("w1c_read_preclear", port_data, 16'h0001);
    chk("w1c_pending", {15'b0, key_pending}, 16'h0000);

    // Release (no edge), then a press landing on the same cycle as a clear
    repeat (8) cycle_in(16'h1000, 1'b0, 16'h0, 10'h203, 3'b111);
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) cycle_in(16'h3002, 1'b1, 16'h0007, 10'h203, 3'b110);
      else        cycle_in(16'h1000, 1'b0, 16'h0, 10'h203, 3'b110);
    end
    chk("set_beats_clear", {15'b0, key_pending}, 16'h0001);

    // Writes to other offsets and other windows leave the edge alone
    cycle_in(16'h3000, 1'b1, 16'hFFFF, 10'h155, 3'b110);
    cycle_in(16'h3001, 1'b1, 16'hFFFF, 10'h0AA, 3'b110);
    cycle_in(16'h3003, 1'b1, 16'hFFFF, 10'h0AA, 3'b110);
    cycle_in(16'h1002, 1'b1, 16'hFFFF, 10'h0AA, 3'b110);
    cycle_in(16'h3002, 1'b0, 16'h0, 10'h0AA, 3'b110);
    chk("ignored_writes", port_data, 16'h0001);
    cycle_in(16'h3003, 1'b0, 16'h0, 10'h0AA, 3'b110);
    chk("reserved_offset", port_data, 16'h0000);

    // Reset mid-debounce: full debounce needed again afterwards
    repeat (8) cycle_in(16'h3002, 1'b1, 16'h0007, 10'h0AA, 3'b111);
    repeat (4) cycle_in(16'h1000, 1'b0, 16'h0, 10'h0AA, 3'b011);
    do_reset(2);
    for (int i = 1; i <= 6; i++) begin
      cycle_in(16'h3001, 1'b0, 16'h0, 10'h0AA, 3'b011);
      if (i == 5) chk("post_reset_early", {15'b0, key_pending}, 16'h0000);
      if (i == 6) chk("post_reset_press", {15'b0, key_pending}, 16'h0001);
    end

    // Randomized traffic with slowly changing keys and one mid-run reset
    sw_r  = 10'($urandom);
    key_r = 3'b111;
    for (int n = 0; n < 800; n++) begin
      if (n == 400) do_reset(1 + int'($urandom_range(2)));
      for (int b = 0; b < 3; b++)
        if ($urandom_range(5) == 0) key_r[b] = ~key_r[b];
      if ($urandom_range(7) == 0) sw_r = 10'($urandom);
      a = 16'($urandom);
      if ($urandom_range(3) != 0) a[15:12] = 4'h3;
      cycle_in(a, ($urandom_range(3) == 0), 16'($urandom), sw_r, key_r);
    end

    @(negedge CLOCK_50);
    #1;
    chk("scoreboard_drain", 16'(q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
